// File: rtl/fnd_scan_ctrl.sv
// Four-digit 7-segment scan controller: converts a 14-bit binary value to BCD by
// double-dabble and multiplexes the digits onto a shared decoder input.
module fnd_scan_ctrl #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        iClk,
    input  logic        iRsn,
    input  logic [13:0] iValue,
    input  logic        iValid,
    output logic        oReady,
    output logic        oDone,
    output logic        oOvf,
    output logic [3:0]  oDec,
    output logic [3:0]  oDigitSel
);

    localparam int unsigned PreW = $clog2(SCAN_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);
    localparam logic [13:0] MaxVal = 14'd9999;

    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StLoad
    } stateT;

    stateT             state, stateNext;
    logic [13:0]       binReg, binNext;
    logic [15:0]       bcdReg, bcdNext;
    logic [3:0]        iterCnt, iterNext;
    logic [15:0]       dispReg, dispNext;
    logic              ovfNext, doneNext;
    logic [PreW-1:0]   preCnt, preNext;
    logic [1:0]        idx, idxNext;
    logic [3:0]        decNext, selNext;

    function automatic logic [15:0] dabAdjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    assign oReady = (state == StIdle);

    always_comb begin
        stateNext = state;
        binNext   = binReg;
        bcdNext   = bcdReg;
        iterNext  = iterCnt;
        dispNext  = dispReg;
        ovfNext   = oOvf;
        doneNext  = 1'b0;
        unique case (state)
            StIdle: begin
                if (iValid) begin
                    binNext   = (iValue > MaxVal) ? MaxVal : iValue;
                    ovfNext   = (iValue > MaxVal);
                    bcdNext   = '0;
                    iterNext  = '0;
                    stateNext = StConv;
                end
            end
            StConv: begin
                {bcdNext, binNext} = {dabAdjust(bcdReg), binReg} << 1;
                iterNext = iterCnt + 4'd1;
                if (iterCnt == 4'd13) begin
                    stateNext = StLoad;
                end
            end
            StLoad: begin
                // All four nibbles land together so the scan never shows a mixed value.
                dispNext  = bcdReg;
                doneNext  = 1'b1;
                stateNext = StIdle;
            end
            default: stateNext = StIdle;
        endcase
    end

    // Scan outputs are computed from next-state values so a LOAD is visible
    // on the same edge that raises oDone.
    always_comb begin
        if (preCnt == PreMax) begin
            preNext = '0;
            idxNext = idx + 2'd1;
        end else begin
            preNext = preCnt + PreW'(1);
            idxNext = idx;
        end
        decNext = dispNext[{idxNext, 2'b00} +: 4];
        selNext = ~(4'b0001 << idxNext);
    end

    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state     <= StIdle;
            binReg    <= '0;
            bcdReg    <= '0;
            iterCnt   <= '0;
            dispReg   <= '0;
            oOvf      <= 1'b0;
            oDone     <= 1'b0;
            preCnt    <= '0;
            idx       <= '0;
            oDec      <= '0;
            oDigitSel <= 4'b1110;
        end else begin
            state     <= stateNext;
            binReg    <= binNext;
            bcdReg    <= bcdNext;
            iterCnt   <= iterNext;
            dispReg   <= dispNext;
            oOvf      <= ovfNext;
            oDone     <= doneNext;
            preCnt    <= preNext;
            idx       <= idxNext;
            oDec      <= decNext;
            oDigitSel <= selNext;
        end
    end

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Self-checking bench for fnd_scan_ctrl: vector table, corner sequences and a
// cycle-level reference model of the display behaviour.
module tb_fnd_scan_ctrl;

    localparam int unsigned DIV = 4;

    logic        iClk = 1'b0;
    logic        iRsn = 1'b1;
    logic [13:0] iValue = '0;
    logic        iValid = 1'b0;
    logic        oReady, oDone, oOvf;
    logic [3:0]  oDec, oDigitSel;

    fnd_scan_ctrl #(.SCAN_DIV(DIV)) dut (
        .iClk(iClk),
        .iRsn(iRsn),
        .iValue(iValue),
        .iValid(iValid),
        .oReady(oReady),
        .oDone(oDone),
        .oOvf(oOvf),
        .oDec(oDec),
        .oDigitSel(oDigitSel)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int errors = 0;
    int doneCount = 0;

    // Reference model state: busy countdown, pending value, shown value, edges since reset.
    bit mReady, mOvf, mDone;
    int mBusy, mPend, mDisp, mEdge;

    typedef struct {
        int value;
        int expShown;
        bit expOvf;
    } vecT;

    vecT vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int digitOf(input int v, input int pos);
        int x = v;
        for (int i = 0; i < pos; i++) x = x / 10;
        return x % 10;
    endfunction

    function automatic int selToIdx(input logic [3:0] s);
        case (s)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic modelReset();
        mReady = 1; mOvf = 0; mDone = 0;
        mBusy = 0; mPend = 0; mDisp = 0; mEdge = 0;
    endtask

    task automatic modelStep();
        mEdge++;
        mDone = 0;
        if (mReady) begin
            if (iValid) begin
                mReady = 0;
                mBusy  = 15;
                mPend  = (iValue > 9999) ? 9999 : int'(iValue);
                mOvf   = (iValue > 9999);
            end
        end else begin
            mBusy--;
            if (mBusy == 0) begin
                mReady = 1;
                mDisp  = mPend;
                mDone  = 1;
            end
        end
    endtask

    task automatic checkOutputs();
        int k;
        k = (mEdge / DIV) % 4;
        chk("model_ready", int'(oReady), int'(mReady));
        chk("model_done", int'(oDone), int'(mDone));
        chk("model_ovf", int'(oOvf), int'(mOvf));
        chk("model_dec", int'(oDec), digitOf(mDisp, k));
        chk("model_sel", int'(oDigitSel), (~(1 << k)) & 15);
    endtask

    task automatic tick();
        @(posedge iClk);
        modelStep();
        @(negedge iClk);
        checkOutputs();
        if (oDone) doneCount++;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (!oDone && n < 40) begin
            tick();
            n++;
        end
        if (!oDone) chk({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic submit(input int v);
        iValue = 14'(v);
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
    endtask

    task automatic readDisplay(output int shown);
        int d[4];
        int k;
        for (int i = 0; i < 4; i++) d[i] = 0;
        repeat (4 * DIV) begin
            tick();
            k = selToIdx(oDigitSel);
            if (k >= 0) d[k] = int'(oDec);
        end
        shown = d[3] * 1000 + d[2] * 100 + d[1] * 10 + d[0];
    endtask

    initial begin
        int shown, n, bad, k;

        vecs[0] = '{1234, 1234, 1'b0};
        vecs[1] = '{12000, 9999, 1'b1};
        vecs[2] = '{0, 0, 1'b0};
        vecs[3] = '{9999, 9999, 1'b0};
        vecs[4] = '{10000, 9999, 1'b1};
        vecs[5] = '{16383, 9999, 1'b1};
        vecs[6] = '{1, 1, 1'b0};
        vecs[7] = '{5555, 5555, 1'b0};
        vecs[8] = '{909, 909, 1'b0};
        vecs[9] = '{8090, 8090, 1'b0};

        // Asynchronous reset, checked before any clock edge.
        #1 iRsn = 1'b0;
        #1;
        chk("rst_ready", int'(oReady), 1);
        chk("rst_done", int'(oDone), 0);
        chk("rst_ovf", int'(oOvf), 0);
        chk("rst_dec", int'(oDec), 0);
        chk("rst_sel", int'(oDigitSel), 4'b1110);
        modelReset();
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRsn = 1'b1;

        // Accept 1234 and measure the busy window.
        iValue = 14'd1234;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        n = 0;
        while (oReady == 1'b0 && n < 40) begin
            n++;
            tick();
        end
        chk("latency_ready_low", n, 15);
        chk("latency_done_pulse", int'(oDone), 1);
        readDisplay(shown);
        chk("first_display", shown, 1234);

        foreach (vecs[i]) begin
            submit(vecs[i].value);
            waitDone($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_ovf", i), int'(oOvf), int'(vecs[i].expOvf));
            readDisplay(shown);
            chk($sformatf("vec%0d_display", i), shown, vecs[i].expShown);
        end

        // A pulse of iValid during CONV is dropped.
        doneCount = 0;
        submit(42);
        tick();
        tick();
        iValue = 14'd5555;
        iValid = 1'b1;
        tick();
        iValid = 1'b0;
        waitDone("ignore");
        readDisplay(shown);
        chk("ignore_display", shown, 42);
        chk("ignore_done_count", doneCount, 1);

        // iValid held high through completion is taken at E16.
        iValue = 14'd42;
        iValid = 1'b1;
        tick();
        iValue = 14'd5555;
        repeat (15) tick();
        chk("hold_ready_e15", int'(oReady), 1);
        tick();
        chk("hold_accept_e16", int'(oReady), 0);
        iValid = 1'b0;
        waitDone("hold");
        readDisplay(shown);
        chk("hold_display", shown, 5555);

        // No partial digits while converting over a shown value.
        submit(777);
        waitDone("seq777");
        readDisplay(shown);
        chk("seq777_display", shown, 777);
        submit(8001);
        n = 0;
        bad = 0;
        while (oReady == 1'b0 && n < 40) begin
            if (oDec != 4'd0 && oDec != 4'd7) bad++;
            n++;
            tick();
        end
        chk("conv_old_digits_only", bad, 0);
        bad = 0;
        repeat (4 * DIV) begin
            if (oDec != 4'd8 && oDec != 4'd0 && oDec != 4'd1) bad++;
            tick();
        end
        chk("load_new_digits_only", bad, 0);

        // Reset in the middle of a conversion aborts it.
        doneCount = 0;
        submit(12000);
        repeat (6) tick();
        #1 iRsn = 1'b0;
        #1;
        chk("abort_ready", int'(oReady), 1);
        chk("abort_done", int'(oDone), 0);
        chk("abort_ovf", int'(oOvf), 0);
        chk("abort_dec", int'(oDec), 0);
        chk("abort_sel", int'(oDigitSel), 4'b1110);
        modelReset();
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iRsn = 1'b1;
        chk("abort_release_ready", int'(oReady), 1);
        readDisplay(shown);
        chk("abort_display", shown, 0);
        chk("abort_no_done", doneCount, 0);

        // Random traffic against the model, iValid toggling in every state.
        for (int c = 0; c < 3000; c++) begin
            k = int'($urandom_range(0, 9));
            if (k == 0) iValue = 14'd9999;
            else if (k == 1) iValue = 14'd10000;
            else iValue = 14'($urandom_range(0, 16383));
            iValid = ($urandom_range(0, 3) != 0);
            tick();
        end
        iValid = 1'b0;
        repeat (20) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 SCAN_DIV, 50000, clock cycles each digit stays selected; legal range 2..2^20.
REQ-002 iClk  input  1  system clock; all state changes on the rising edge.
REQ-003 iRsn  input  1  reset; asynchronous, active-low.
REQ-004 iValue  input  14  unsigned binary value to display, e.g. the temperature reading.
REQ-005 iValid  input  1  iValue is valid this cycle.
REQ-006 oReady  output  1  block can accept a value; high only in IDLE.
REQ-007 oDone  output  1  one-cycle pulse when new digits become visible.
REQ-008 oOvf  output  1  last accepted value exceeded 9999 and was saturated.
REQ-009 oDec  output  4  BCD digit (0..9) for the currently selected position; drives the 7-segment decoder input.
REQ-010 oDigitSel  output  4  active-low one-hot digit enable; bit0 = ones, bit3 = thousands.

Function
REQ-011 States SHALL be IDLE, CONV and LOAD, and oReady SHALL equal (state==IDLE).
REQ-012 Handshake: a value SHALL be accepted on an edge where iValid=1 and oReady=1; iValid in any other state SHALL be ignored, with no queuing.
REQ-013 Capture: on the accept edge, the block SHALL latch min(iValue, 9999), set oOvf=(iValue>9999), clear the BCD shift register and go to CONV.
REQ-014 CONV: the block SHALL run exactly 14 double-dabble iterations, one per edge.
- Each iteration: add 3 to every BCD nibble that is >=5, then shift {BCD, binary} left by 1.
- The 14th iteration edge SHALL move the state to LOAD.
REQ-015 LOAD: on the next edge, all four BCD nibbles SHALL be written atomically into the display registers, oDone SHALL be registered high for exactly one cycle, and the state SHALL return to IDLE.
REQ-016 Latency: with accept at edge E0, new digits and oDone SHALL be visible after edge E15, and oReady SHALL be high again after E15.
- Back-to-back acceptance: the earliest next accept is E16.
REQ-017 Display registers SHALL change only in LOAD, so scanning during CONV shows the previous value with no partial digits.
REQ-018 Prescaler: counts 0..SCAN_DIV-1 and wraps to 0.
- At terminal count, the digit index (0..3) SHALL advance by one and wrap 3->0.
- Scanning SHALL run continuously in every state.
REQ-019 Outputs: oDigitSel SHALL be the registered active-low one-hot of the index (0 -> 4'b1110, 3 -> 4'b0111), and oDec SHALL be the display nibble of the same index, both updated on the same edge.
REQ-020 oDec SHALL always be in 0..9; codes 10..15 SHALL never be produced.
REQ-021 Leading zeros SHALL be displayed, with no blanking.

Reset
REQ-022 While iRsn=0, independent of iClk:
- state = IDLE, oReady = 1, oDone = 0, oOvf = 0;
- display registers = 0, BCD/shift registers = 0;
- prescaler = 0, index = 0, oDigitSel = 4'b1110, oDec = 0.
REQ-023 Reset asserted during CONV or LOAD SHALL abort the conversion with no display update and no oDone; after release the block SHALL be in IDLE and ready.
REQ-024 After release, the first index advance SHALL occur SCAN_DIV edges later.

Verification (SCAN_DIV=4)
REQ-025 Reset, then drive iValue=1234 and iValid=1 for one cycle.
- Expected: oReady low for 15 cycles; oDone pulses one cycle after E15.
- Then oDec/oDigitSel cycle through 4/1110, 3/1101, 2/1011, 1/0111, each held for 4 cycles.
REQ-026 iValue=12000 -> digits 9,9,9,9 with oOvf=1; then iValue=0 -> digits 0,0,0,0 with oOvf=0.
REQ-027 Pulse iValid with iValue=5555 at E3 of a conversion of 42.
- Expected: 5555 ignored; display becomes 0042 with one oDone.
- Hold iValid high through completion: 5555 is accepted at E16.
REQ-028 Display 0777, then start a conversion of 8001 while scanning.
- During CONV the sampled oDec values come only from {0,7}.
- After LOAD they come only from {8,0,1}.
REQ-029 Assert iRsn=0 at E7 of a conversion.
- Expected: outputs take reset values immediately (asynchronously); no oDone occurs.
- After release, oReady=1 and the display reads 0000.
REQ-030 Exhaustive iValue 0..9999: every display nibble SHALL equal the decimal digit of the value.
